stats_uart_tx: RTL and testbench

Frame-level UART transmitter for the tamagotchi. On each `send` request it snapshots the five 5-bit pet stats and the sleep flag, builds a fixed 8-byte frame (header, stats, flags, XOR checksum) and serializes it 8N1 on `uart_tx`. It is the outbound counterpart of the command receiver path: the receiver turns host bytes into `inputs`, and this block reports pet state back to the host. It is driven from the top level by the one-second tick.

---
 rtl/tama_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 112 +++++++++++
 rtl/stats_uart_tx.sv | 110 +++++++++++
 tb/tb_stats_uart_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// Shared definitions for the tamagotchi host link (status transmitter and command receiver).
// Contents: frame constants, stat width, the UART frame-FSM state type and a stat-to-byte helper.
package tama_pkg;

  localparam logic [7:0]  FRAME_HEADER = 8'hA5;
  localparam int unsigned FRAME_LEN    = 8;
  localparam int unsigned STAT_W       = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } frame_state_t;

  // Zero-extends a stat value to one frame byte.
  function automatic logic [7:0] stat_byte(input logic [STAT_W-1:0] s);
    return {{(8 - STAT_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   load, data      - byte request; accepted when idle or on the final cycle of a stop bit
//   last            - tag carried with the byte; echoed on done_last when that byte completes
//   tx              - serial line, idles high (registered)
//   busy            - byte in progress (registered)
//   done, done_last - one-cycle pulses when a byte's stop bit ends (registered)
module uart_tx_byte
  import tama_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       last,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       done_last
);

  localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  frame_state_t    state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_last <= 1'b0;
    end else begin
      done      <= 1'b0;
      done_last <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx        <= 1'b1;
          busy      <= 1'b0;
          clk_cnt_q <= '0;
          if (load) begin
            shift_q <= data;
            last_q  <= last;
            state_q <= StStart;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (clk_cnt_q == CntMax) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx        <= shift_q[0];
            state_q   <= StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (clk_cnt_q == CntMax) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              // Shift right so the next data bit is always at position 1.
              bit_idx_q <= bit_idx_q + 3'd1;
              tx        <= shift_q[1];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (clk_cnt_q == CntMax) begin
            clk_cnt_q <= '0;
            done      <= 1'b1;
            done_last <= last_q;
            if (load) begin
              // Chain straight into the next start bit: no inter-byte gap.
              shift_q <= data;
              last_q  <= last;
              tx      <= 1'b0;
              state_q <= StStart;
            end else begin
              tx      <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/stats_uart_tx.sv
// Pet-status frame transmitter: on send, snapshots the five stats and the sleep flag and sends
// the 8-byte frame HEADER, stats, flags, XOR checksum (bytes 1..6) as 8N1 on uart_tx.
// Ports:
//   clk, reset                                     - system clock, async active-high reset
//   send                                           - frame request, ignored while busy
//   hunger, happiness, hygiene, energy, social     - live 5-bit stats
//   is_sleeping                                    - live sleep flag
//   uart_tx                                        - serial line, idles high
//   busy                                           - frame in progress
//   frame_done                                     - one-cycle pulse at the end of a frame
module stats_uart_tx
  import tama_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter logic [7:0]  HEADER       = FRAME_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send,
  input  logic [STAT_W-1:0] hunger,
  input  logic [STAT_W-1:0] happiness,
  input  logic [STAT_W-1:0] hygiene,
  input  logic [STAT_W-1:0] energy,
  input  logic [STAT_W-1:0] social,
  input  logic              is_sleeping,
  output logic              uart_tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [3:0] IdxEnd  = 4'(FRAME_LEN);
  localparam logic [3:0] IdxLast = 4'(FRAME_LEN - 1);

  logic [STAT_W-1:0] hunger_q, happiness_q, hygiene_q, energy_q, social_q;
  logic              sleep_q;
  // Index of the next byte to hand to the serializer (the header is loaded on acceptance).
  logic [3:0]        next_idx_q;

  logic [7:0] checksum;
  logic [7:0] frame_byte;
  logic [7:0] ld_data;
  logic       ld;
  logic       ld_last;
  logic       byte_done;

  always_comb begin
    checksum = stat_byte(hunger_q) ^ stat_byte(happiness_q) ^ stat_byte(hygiene_q) ^
               stat_byte(energy_q) ^ stat_byte(social_q) ^ {7'b0, sleep_q};
    case (next_idx_q[2:0])
      3'd1:    frame_byte = stat_byte(hunger_q);
      3'd2:    frame_byte = stat_byte(happiness_q);
      3'd3:    frame_byte = stat_byte(hygiene_q);
      3'd4:    frame_byte = stat_byte(energy_q);
      3'd5:    frame_byte = stat_byte(social_q);
      3'd6:    frame_byte = {7'b0, sleep_q};
      3'd7:    frame_byte = checksum;
      default: frame_byte = HEADER;
    endcase
    // The serializer only consumes load when idle or at the end of a stop bit, so holding the
    // pending byte on the bus for the whole byte time is safe.
    if (busy) begin
      ld      = (next_idx_q != IdxEnd);
      ld_data = frame_byte;
      ld_last = (next_idx_q == IdxLast);
    end else begin
      ld      = send;
      ld_data = HEADER;
      ld_last = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hunger_q    <= '0;
      happiness_q <= '0;
      hygiene_q   <= '0;
      energy_q    <= '0;
      social_q    <= '0;
      sleep_q     <= 1'b0;
      next_idx_q  <= '0;
    end else if (!busy) begin
      if (send) begin
        hunger_q    <= hunger;
        happiness_q <= happiness;
        hygiene_q   <= hygiene;
        energy_q    <= energy;
        social_q    <= social;
        sleep_q     <= is_sleeping;
        next_idx_q  <= 4'd1;
      end
    end else if (byte_done && next_idx_q != IdxEnd) begin
      next_idx_q <= next_idx_q + 4'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .data     (ld_data),
    .last     (ld_last),
    .tx       (uart_tx),
    .busy     (busy),
    .done     (byte_done),
    .done_last(frame_done)
  );

endmodule

// File: tb/tb_stats_uart_tx.sv
// Self-checking bench for stats_uart_tx with CLKS_PER_BIT = 4 (320-cycle frames).
module tb_stats_uart_tx;

  localparam int Cpb      = 4;
  localparam int FrameCyc = 80 * Cpb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [4:0] hunger = '0, happiness = '0, hygiene = '0, energy = '0, social = '0;
  logic       is_sleeping = 1'b0;
  logic       uart_tx, busy, frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_stamp = 0;

  logic [7:0] exp_frame [8];

  stats_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .HEADER      (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .hunger     (hunger),
    .happiness  (happiness),
    .hygiene    (hygiene),
    .energy     (energy),
    .social     (social),
    .is_sleeping(is_sleeping),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference frame from the current stat inputs.
  task automatic make_expected();
    exp_frame[0] = 8'hA5;
    exp_frame[1] = {3'b0, hunger};
    exp_frame[2] = {3'b0, happiness};
    exp_frame[3] = {3'b0, hygiene};
    exp_frame[4] = {3'b0, energy};
    exp_frame[5] = {3'b0, social};
    exp_frame[6] = {7'b0, is_sleeping};
    exp_frame[7] = 8'h00;
    for (int i = 1; i <= 6; i++) exp_frame[7] = exp_frame[7] ^ exp_frame[i];
  endtask

  // Expected line level k cycles after the accepting edge.
  function automatic logic exp_bit(input int k);
    int bitn, pos;
    logic [7:0] b;
    bitn = k / Cpb;
    pos  = bitn % 10;
    b    = exp_frame[bitn / 10];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos - 1];
  endfunction

  task automatic randomize_stats();
    hunger      = 5'($urandom_range(31));
    happiness   = 5'($urandom_range(31));
    hygiene     = 5'($urandom_range(31));
    energy      = 5'($urandom_range(31));
    social      = 5'($urandom_range(31));
    is_sleeping = 1'($urandom_range(1));
  endtask

  task automatic idle_check(input int n, input string tag);
    int e_tx = 0, e_busy = 0, e_done = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) e_tx++;
      if (busy !== 1'b0) e_busy++;
      if (frame_done !== 1'b0) e_done++;
    end
    check_eq({tag, "_tx_errs"}, e_tx, 0);
    check_eq({tag, "_busy_errs"}, e_busy, 0);
    check_eq({tag, "_done_errs"}, e_done, 0);
  endtask

  // Raise send with the current stats and return just after the accepting edge.
  task automatic start_frame();
    @(negedge clk);
    make_expected();
    send = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; returns at the sample point after the frame_done edge.
  task automatic check_frame(input bit keep_send, input int change_at, input int pulse_at);
    logic [7:0] got [8];
    int e_tx = 0, e_busy = 0, e_done = 0;
    int bitn, pos;
    for (int i = 0; i < 8; i++) got[i] = 8'h00;
    for (int k = 0; k <= FrameCyc; k++) begin
      @(negedge clk);
      if (k < FrameCyc) begin
        if (uart_tx !== exp_bit(k)) e_tx++;
        if (busy !== 1'b1) e_busy++;
        if (frame_done !== 1'b0) e_done++;
        if (k % Cpb == Cpb / 2) begin
          bitn = k / Cpb;
          pos  = bitn % 10;
          if (pos >= 1 && pos <= 8) got[bitn / 10][pos - 1] = uart_tx;
        end
      end else begin
        check_eq("end_busy", busy, 0);
        check_eq("end_frame_done", frame_done, 1);
        check_eq("end_tx", uart_tx, 1);
        done_stamp = cyc;
      end
      if (k == 0 && !keep_send) send = 1'b0;
      if (k == change_at) randomize_stats();
      if (k == pulse_at) send = 1'b1;
      if (k == pulse_at + 1 && !keep_send) send = 1'b0;
    end
    check_eq("wave_tx_errs", e_tx, 0);
    check_eq("wave_busy_errs", e_busy, 0);
    check_eq("wave_done_errs", e_done, 0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("byte%0d", i), got[i], exp_frame[i]);
  endtask

  initial begin
    int stamp_a;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", uart_tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    idle_check(1000, "idle");

    // Fixed vector: A5 1F 00 0A 01 10 01 05.
    hunger = 5'd31; happiness = 5'd0; hygiene = 5'd10; energy = 5'd1; social = 5'd16;
    is_sleeping = 1'b1;
    start_frame();
    check_frame(1'b0, -1, -1);
    check_eq("vector_checksum", exp_frame[7], {3'b0, hunger} ^ {3'b0, happiness} ^
             {3'b0, hygiene} ^ {3'b0, energy} ^ {3'b0, social} ^ {7'b0, is_sleeping});

    // Stats change mid-frame: the frame in flight keeps the snapshot, the next one sees new values.
    randomize_stats();
    start_frame();
    check_frame(1'b0, 50, -1);
    start_frame();
    check_frame(1'b0, -1, -1);

    // send held high: back-to-back frames; new stats presented in the frame_done cycle.
    randomize_stats();
    start_frame();
    stamp_a = 0;
    for (int f = 0; f < 4; f++) begin
      check_frame(1'b1, -1, -1);
      if (f > 0) check_eq("done_period", done_stamp - stamp_a, FrameCyc + 1);
      stamp_a = done_stamp;
      randomize_stats();
      make_expected();
      if (f == 3) send = 1'b0;
      else @(posedge clk);
    end
    idle_check(20, "after_held");

    // Pulses while busy are dropped, including one sampled on the final stop-bit edge.
    randomize_stats();
    start_frame();
    check_frame(1'b0, -1, 150);
    randomize_stats();
    start_frame();
    check_frame(1'b0, -1, FrameCyc - 1);
    idle_check(400, "no_extra");

    // Reset mid-frame: line high and not busy without waiting for a clock edge.
    randomize_stats();
    start_frame();
    @(negedge clk);
    send = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_tx", uart_tx, 1);
    check_eq("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(10, "post_rst");
    randomize_stats();
    start_frame();
    check_frame(1'b0, -1, -1);

    // Random frames with random mid-frame pulses and stat changes.
    for (int r = 0; r < 5; r++) begin
      randomize_stats();
      repeat ($urandom_range(3)) @(negedge clk);
      start_frame();
      check_frame(1'b0, int'($urandom_range(300, 10)), int'($urandom_range(318, 2)));
    end
    idle_check(50, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
